fetch_queue_mw: RTL and testbench

Parametrised multi-way instruction fetch queue between the fetch stage and decode/rename. Each cycle it accepts a variable count (0..WAY) of contiguous instruction words from fetch and delivers up to WAY of the oldest words to decode, which consumes a variable count (0..WAY). It supports partial fetch groups, such as a branch target landing on an odd word, partial decode consumption and single-cycle flush on redirect. Storage is a circular buffer with wrap-bit pointers.

---
 rtl/fetch_queue_mw.sv | 134 +++++++++++++
 tb/tb_fetch_queue_mw.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_mw.sv
// fetch_queue_mw
//   Multi-way instruction fetch queue sitting between fetch and decode/rename.
//   Fetch pushes 0..WAY contiguous words per cycle; decode sees up to WAY of
//   the oldest words and consumes 0..WAY of them. Storage is a circular
//   buffer addressed by head/tail pointers carrying an extra wrap bit, so
//   full and empty are distinguishable without a separate counter.
//
// Ports
//   clk              rising-edge clock
//   rst              asynchronous, active-low reset (pointers only)
//   flush            discard all contents on the next edge (beats push/pop)
//   enq_data         WAY lanes, lanes 0..enq_count-1 valid, lane 0 oldest
//   enq_count        number of lanes to push
//   enq_ready        at least WAY free slots (registered state only)
//   enq_drop         push attempted while not ready; fetch must hold
//   deq_data         oldest entries, lane 0 = head; unused lanes are 0
//   deq_valid_count  min(occupancy, WAY)
//   deq_count        lanes consumed this cycle (clamped to deq_valid_count)
//   occupancy        entries held, 0..DEPTH
//   full / empty     occupancy == DEPTH / occupancy == 0

module fetch_queue_mw #(
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned WAY        = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PTR_W      = $clog2(DEPTH),
    parameter int unsigned CNT_W      = $clog2(WAY + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [WAY-1:0][DATA_WIDTH-1:0]   enq_data,
    input  logic [CNT_W-1:0]                 enq_count,
    output logic                             enq_ready,
    output logic                             enq_drop,
    output logic [WAY-1:0][DATA_WIDTH-1:0]   deq_data,
    output logic [CNT_W-1:0]                 deq_valid_count,
    input  logic [CNT_W-1:0]                 deq_count,
    output logic [PTR_W:0]                   occupancy,
    output logic                             full,
    output logic                             empty
);

    localparam int unsigned OCC_W = PTR_W + 1;

    logic [OCC_W-1:0]      head_q, head_d;
    logic [OCC_W-1:0]      tail_q, tail_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]      wr_addr [WAY];
    logic [PTR_W-1:0]      rd_addr [WAY];
    logic                  push_req;
    logic                  push_fire;
    logic [CNT_W-1:0]      pop_n;

    // Status: everything except enq_drop depends only on registered pointers.
    always_comb begin
        occupancy = tail_q - head_q;
        empty     = (occupancy == '0);
        full      = (occupancy == OCC_W'(DEPTH));
        enq_ready = (occupancy <= OCC_W'(DEPTH - WAY));
        if (occupancy >= OCC_W'(WAY)) begin
            deq_valid_count = CNT_W'(WAY);
        end else begin
            deq_valid_count = occupancy[CNT_W-1:0];
        end
    end

    // Slot addresses wrap naturally through the PTR_W-bit truncation.
    always_comb begin
        for (int unsigned i = 0; i < WAY; i++) begin
            wr_addr[i] = tail_q[PTR_W-1:0] + PTR_W'(i);
            rd_addr[i] = head_q[PTR_W-1:0] + PTR_W'(i);
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < WAY; i++) begin
            if (CNT_W'(i) < deq_valid_count) begin
                deq_data[i] = mem_q[rd_addr[i]];
            end else begin
                deq_data[i] = '0;
            end
        end
    end

    // Flush wins over both push and pop, and never reports a drop.
    always_comb begin
        push_req  = (enq_count != '0);
        push_fire = push_req && enq_ready && !flush;
        enq_drop  = push_req && !enq_ready && !flush;
        if (deq_count < deq_valid_count) begin
            pop_n = deq_count;
        end else begin
            pop_n = deq_valid_count;
        end
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            head_d = head_q + OCC_W'(pop_n);
            if (push_fire) begin
                tail_d = tail_q + OCC_W'(enq_count);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Array is deliberately not reset; empty pointers hide stale contents.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            for (int unsigned i = 0; i < WAY; i++) begin
                if (CNT_W'(i) < enq_count) begin
                    mem_q[wr_addr[i]] <= enq_data[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue_mw.sv
module tb_fetch_queue_mw;

    localparam int DEPTH = 32;
    localparam int WAY   = 2;
    localparam int DW    = 32;
    localparam int PTR_W = 5;
    localparam int CNT_W = 2;

    logic                     clk;
    logic                     rst;
    logic                     flush;
    logic [WAY-1:0][DW-1:0]   enq_data;
    logic [CNT_W-1:0]         enq_count;
    logic                     enq_ready;
    logic                     enq_drop;
    logic [WAY-1:0][DW-1:0]   deq_data;
    logic [CNT_W-1:0]         deq_valid_count;
    logic [CNT_W-1:0]         deq_count;
    logic [PTR_W:0]           occupancy;
    logic                     full;
    logic                     empty;

    fetch_queue_mw #(
        .DEPTH(DEPTH),
        .WAY(WAY),
        .DATA_WIDTH(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .enq_data(enq_data),
        .enq_count(enq_count),
        .enq_ready(enq_ready),
        .enq_drop(enq_drop),
        .deq_data(deq_data),
        .deq_valid_count(deq_valid_count),
        .deq_count(deq_count),
        .occupancy(occupancy),
        .full(full),
        .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int clamp_events = 0;

    // Scoreboard / reference model: words in queue order, head at index 0.
    logic [DW-1:0] sb[$];

    // Over-consumption is legal but noted; the total is checked at the end.
    always @(negedge clk) begin
        if (rst && !flush && (deq_count > deq_valid_count)) clamp_events++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered at posedge+1. Drives one cycle, checks outputs against the
    // model before the edge, then advances the model across the edge.
    task automatic step(input int ec, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input int dc, input bit fl);
        int sz, vce, n;
        bit rdy;
        logic [DW-1:0] lane_e;
        flush     = fl;
        enq_count = CNT_W'(ec);
        enq_data[0] = d0;
        enq_data[1] = d1;
        deq_count = CNT_W'(dc);
        #3;
        sz  = sb.size();
        vce = (sz < WAY) ? sz : WAY;
        rdy = (sz <= DEPTH - WAY);
        chk("occupancy", 64'(occupancy), 64'(sz));
        chk("empty", 64'(empty), 64'(sz == 0));
        chk("full", 64'(full), 64'(sz == DEPTH));
        chk("enq_ready", 64'(enq_ready), 64'(rdy));
        chk("enq_drop", 64'(enq_drop), 64'(!fl && ec != 0 && !rdy));
        chk("deq_valid_count", 64'(deq_valid_count), 64'(vce));
        for (int i = 0; i < WAY; i++) begin
            lane_e = (i < vce) ? sb[i] : '0;
            chk($sformatf("deq_data[%0d]", i), 64'(deq_data[i]), 64'(lane_e));
        end
        if (fl) begin
            sb.delete();
        end else begin
            n = (dc < vce) ? dc : vce;
            for (int i = 0; i < n; i++) void'(sb.pop_front());
            if (ec != 0 && rdy) begin
                sb.push_back(d0);
                if (ec > 1) sb.push_back(d1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_occ"}, 64'(occupancy), 64'd0);
        chk({tag, "_empty"}, 64'(empty), 64'd1);
        chk({tag, "_full"}, 64'(full), 64'd0);
        chk({tag, "_ready"}, 64'(enq_ready), 64'd1);
        chk({tag, "_drop"}, 64'(enq_drop), 64'd0);
        chk({tag, "_vc"}, 64'(deq_valid_count), 64'd0);
        chk({tag, "_lane0"}, 64'(deq_data[0]), 64'd0);
        chk({tag, "_lane1"}, 64'(deq_data[1]), 64'd0);
    endtask

    // Entered at posedge+1; reset is asserted between edges.
    task automatic do_reset(input string tag);
        flush = 0; enq_count = '0; deq_count = '0; enq_data = '0;
        #1;
        rst = 1'b0;
        #1;
        check_reset_outputs(tag);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int            ec;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        int            dc;
        int            e_occ;
        int            e_vc;
        bit            e_rdy;
        logic [DW-1:0] e_l0;
    } vec_t;

    vec_t tbl[6];

    localparam logic [DW-1:0] A_WORD = 32'hAAAA_0000;
    localparam logic [DW-1:0] B_WORD = 32'hBBBB_0031;
    localparam logic [DW-1:0] C_WORD = 32'hCCCC_0000;

    initial begin
        tbl[0] = '{2, 32'hA000_0000, 32'hA000_0001, 0, 0, 0, 1'b1, 32'h0};
        tbl[1] = '{1, 32'hA000_0002, 32'h0,         0, 2, 2, 1'b1, 32'hA000_0000};
        tbl[2] = '{0, 32'h0,         32'h0,         1, 3, 2, 1'b1, 32'hA000_0000};
        tbl[3] = '{2, 32'hA000_0003, 32'hA000_0004, 2, 2, 2, 1'b1, 32'hA000_0001};
        tbl[4] = '{0, 32'h0,         32'h0,         2, 2, 2, 1'b1, 32'hA000_0003};
        tbl[5] = '{0, 32'h0,         32'h0,         0, 0, 0, 1'b1, 32'h0};

        rst = 1'b0; flush = 0; enq_count = '0; deq_count = '0; enq_data = '0;
        #1;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Table vectors: explicit expectations plus model checks in step().
        for (int v = 0; v < 6; v++) begin
            flush = 0;
            enq_count = CNT_W'(tbl[v].ec);
            enq_data[0] = tbl[v].d0;
            enq_data[1] = tbl[v].d1;
            deq_count = CNT_W'(tbl[v].dc);
            #2;
            chk($sformatf("tbl%0d_occ", v), 64'(occupancy), 64'(tbl[v].e_occ));
            chk($sformatf("tbl%0d_vc", v), 64'(deq_valid_count), 64'(tbl[v].e_vc));
            chk($sformatf("tbl%0d_rdy", v), 64'(enq_ready), 64'(tbl[v].e_rdy));
            chk($sformatf("tbl%0d_lane0", v), 64'(deq_data[0]), 64'(tbl[v].e_l0));
            #(-0);
            step(tbl[v].ec, tbl[v].d0, tbl[v].d1, tbl[v].dc, 1'b0);
        end

        // Mid-run asynchronous reset with two entries held.
        step(2, 32'h1111_0000, 32'h1111_0001, 0, 1'b0);
        chk("pre_reset_occ", 64'(occupancy), 64'd2);
        do_reset("midrst");
        step(0, '0, '0, 0, 1'b0);

        // Odd-word push and wrap: A, then 15 pairs -> tail 31.
        step(1, A_WORD, '0, 0, 1'b0);
        for (int i = 0; i < 15; i++)
            step(2, 32'h5000_0000 + 32'(2 * i), 32'h5000_0001 + 32'(2 * i), 0, 1'b0);
        chk("wrap_tail31", 64'(dut.tail_q), 64'd31);
        step(0, '0, '0, 1, 1'b0);
        step(2, B_WORD, C_WORD, 0, 1'b0);
        chk("wrap_tail_bits", 64'(dut.tail_q), 64'b100001);
        chk("wrap_slot31", 64'(dut.mem_q[31]), 64'(B_WORD));
        chk("wrap_slot0", 64'(dut.mem_q[0]), 64'(C_WORD));
        chk("wrap_full", 64'(full), 64'd1);
        for (int i = 0; i < 15; i++) step(0, '0, '0, 2, 1'b0);
        #2;
        chk("wrap_lane0_B", 64'(deq_data[0]), 64'(B_WORD));
        chk("wrap_lane1_C", 64'(deq_data[1]), 64'(C_WORD));
        chk("wrap_vc", 64'(deq_valid_count), 64'd2);
        step(0, '0, '0, 2, 1'b0);
        do_reset("rst2");

        // Fill to refusal: 1 + 15 pairs = 31 entries in slots 0..30.
        step(1, 32'h7000_0000, '0, 0, 1'b0);
        for (int i = 0; i < 15; i++)
            step(2, 32'h7100_0000 + 32'(i), 32'h7200_0000 + 32'(i), 0, 1'b0);
        #2;
        chk("fill_occ31", 64'(occupancy), 64'd31);
        chk("fill_ready", 64'(enq_ready), 64'd0);
        step(2, 32'hDEAD_0000, 32'hDEAD_0001, 0, 1'b0);
        step(1, 32'hDEAD_0002, '0, 1, 1'b0);
        chk("fill_occ30", 64'(occupancy), 64'd30);
        chk("fill_slot31_untouched", 64'(dut.mem_q[31]), 64'(B_WORD));
        do_reset("rst3");

        // Simultaneous push/pop at occupancy 4 across two pointer wraps.
        step(2, 32'h9000_0000, 32'h9000_0001, 0, 1'b0);
        step(2, 32'h9000_0002, 32'h9000_0003, 0, 1'b0);
        for (int i = 0; i < 40; i++)
            step(2, $urandom, $urandom, 2, 1'b0);
        chk("stream_occ", 64'(occupancy), 64'd4);

        // Partial pop and clamp.
        step(0, '0, '0, 2, 1'b0);
        step(0, '0, '0, 1, 1'b0);
        step(0, '0, '0, 2, 1'b0);
        chk("clamp_empty", 64'(empty), 64'd1);
        chk("clamp_occ", 64'(occupancy), 64'd0);

        // Flush priority at occupancy 10.
        for (int i = 0; i < 5; i++)
            step(2, 32'hF000_0000 + 32'(i), 32'hF100_0000 + 32'(i), 0, 1'b0);
        step(2, 32'hEEEE_0000, 32'hEEEE_0001, 2, 1'b1);
        chk("flush_occ", 64'(occupancy), 64'd0);
        chk("flush_empty", 64'(empty), 64'd1);
        chk("flush_drop", 64'(enq_drop), 64'd0);
        chk("flush_vc", 64'(deq_valid_count), 64'd0);
        step(0, '0, '0, 0, 1'b0);

        chk("clamp_flagged", 64'(clamp_events), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
